// File: rtl/x1_multiplier.sv
// rtl/x1_multiplier.sv - X1 multiplier stage: two partial products into the X1X2 FIFO
module x1_multiplier #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [32:0]  OP1_RX0,
    input  logic [32:0]  OP2_RX0,
    input  logic         SELECT_MSB_RX0,
    input  logic         SIGNED_RES_RX0,
    input  logic         X0X1_EMPTY_SX0,
    output logic         X0X1_POP_SX1,
    input  logic         FLUSH_SX1,
    input  logic         X1X2_POP_SX2,
    output logic [127:0] RES_RX1,
    output logic         SELECT_MSB_RX1,
    output logic         SIGNED_RES_RX1,
    output logic         X1X2_EMPTY_SX1
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [129:0]   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  count;

    logic [63:0]    op1_ext;
    logic [63:0]    op2_lo_ext;
    logic [63:0]    op2_hi_ext;
    logic [63:0]    lo_pp;
    logic [63:0]    hi_pp;
    logic           push;
    logic           pop;

    // Operands widened to 64 bits so that modular 64-bit products equal the
    // sign-extended partial products; the low half of OP2 is always unsigned.
    assign op1_ext    = {{31{OP1_RX0[32]}}, OP1_RX0};
    assign op2_lo_ext = {48'd0, OP2_RX0[15:0]};
    assign op2_hi_ext = {{47{OP2_RX0[32]}}, OP2_RX0[32:16]};
    assign lo_pp      = op1_ext * op2_lo_ext;
    assign hi_pp      = (op1_ext * op2_hi_ext) << 16;

    // A full FIFO still accepts when X2 frees the head in the same cycle.
    assign pop          = X1X2_POP_SX2 && (count != '0);
    assign push         = !X0X1_EMPTY_SX0 && !FLUSH_SX1 &&
                          ((count < FULL_COUNT) || X1X2_POP_SX2);
    assign X0X1_POP_SX1 = push;

    assign {SELECT_MSB_RX1, SIGNED_RES_RX1, RES_RX1} = mem[rd_ptr];
    assign X1X2_EMPTY_SX1 = (count == '0);

    // FIFO storage, pointers and occupancy; flush drops everything queued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (FLUSH_SX1) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {SELECT_MSB_RX0, SIGNED_RES_RX0, hi_pp, lo_pp};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_x1_multiplier.sv
// tb/tb_x1_multiplier.sv - self-checking bench for x1_multiplier
module tb_x1_multiplier;

    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [32:0]  OP1_RX0 = '0;
    logic [32:0]  OP2_RX0 = '0;
    logic         SELECT_MSB_RX0 = 1'b0;
    logic         SIGNED_RES_RX0 = 1'b0;
    logic         X0X1_EMPTY_SX0 = 1'b1;
    logic         X0X1_POP_SX1;
    logic         FLUSH_SX1 = 1'b0;
    logic         X1X2_POP_SX2 = 1'b0;
    logic [127:0] RES_RX1;
    logic         SELECT_MSB_RX1;
    logic         SIGNED_RES_RX1;
    logic         X1X2_EMPTY_SX1;

    x1_multiplier #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .OP1_RX0        (OP1_RX0),
        .OP2_RX0        (OP2_RX0),
        .SELECT_MSB_RX0 (SELECT_MSB_RX0),
        .SIGNED_RES_RX0 (SIGNED_RES_RX0),
        .X0X1_EMPTY_SX0 (X0X1_EMPTY_SX0),
        .X0X1_POP_SX1   (X0X1_POP_SX1),
        .FLUSH_SX1      (FLUSH_SX1),
        .X1X2_POP_SX2   (X1X2_POP_SX2),
        .RES_RX1        (RES_RX1),
        .SELECT_MSB_RX1 (SELECT_MSB_RX1),
        .SIGNED_RES_RX1 (SIGNED_RES_RX1),
        .X1X2_EMPTY_SX1 (X1X2_EMPTY_SX1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        msb;
        logic        sgn;
        logic [63:0] lo;
        logic [63:0] hi;
    } entry_t;

    typedef struct {
        logic [32:0] op1;
        logic [32:0] op2;
        logic        msb;
        logic [63:0] exp_lo;
        logic [63:0] exp_hi;
        logic [63:0] exp_sum;
        logic [31:0] exp_word;
    } vec_t;

    entry_t q[$];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint sext33(input logic [32:0] v);
        return v[32] ? (longint'(v) - (longint'(1) << 33)) : longint'(v);
    endfunction

    // Reference partial products from plain integer arithmetic (wraps mod 2^64).
    function automatic entry_t ref_entry(input logic [32:0] a, input logic [32:0] b,
                                         input logic m, input logic s);
        entry_t e;
        longint sa;
        longint bl;
        longint bh;
        logic [16:0] b_hi;
        logic [15:0] b_lo;
        b_hi = b[32:16];
        b_lo = b[15:0];
        sa = sext33(a);
        bl = longint'(b_lo);
        bh = b_hi[16] ? (longint'(b_hi) - 131072) : longint'(b_hi);
        e.msb = m;
        e.sgn = s;
        e.lo  = sa * bl;
        e.hi  = sa * bh * 65536;
        return e;
    endfunction

    function automatic logic [31:0] x2_word(input logic [63:0] sum, input logic msb);
        return msb ? sum[63:32] : sum[31:0];
    endfunction

    // One clock: drive at the falling edge, check against the model, advance the model.
    task automatic cycle(input logic [32:0] a, input logic [32:0] b, input logic m,
                         input logic s, input logic e, input logic p, input logic f);
        logic exp_push;
        OP1_RX0        = a;
        OP2_RX0        = b;
        SELECT_MSB_RX0 = m;
        SIGNED_RES_RX0 = s;
        X0X1_EMPTY_SX0 = e;
        X1X2_POP_SX2   = p;
        FLUSH_SX1      = f;
        #1;
        exp_push = !e && !f && ((q.size() < DEPTH) || p);
        chk("x0x1_pop", 128'(X0X1_POP_SX1), 128'(exp_push));
        chk("x1x2_empty", 128'(X1X2_EMPTY_SX1), 128'(q.size() == 0));
        if (q.size() > 0) begin
            chk("head_lo", 128'(RES_RX1[63:0]), 128'(q[0].lo));
            chk("head_hi", 128'(RES_RX1[127:64]), 128'(q[0].hi));
            chk("head_msb", 128'(SELECT_MSB_RX1), 128'(q[0].msb));
            chk("head_sgn", 128'(SIGNED_RES_RX1), 128'(q[0].sgn));
        end
        if (f) begin
            q.delete();
        end else begin
            if (p && q.size() > 0) void'(q.pop_front());
            if (exp_push) q.push_back(ref_entry(a, b, m, s));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    vec_t vecs[5];

    initial begin
        logic [63:0] sum;
        logic        save_pop;

        vecs[0] = '{33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 1'b1, 64'h0000FFFEFFFF0001,
                    64'hFFFEFFFF00010000, 64'hFFFFFFFE00000001, 32'hFFFFFFFE};
        vecs[1] = '{33'h1_FFFFFFFD, 33'h0_00000005, 1'b0, 64'hFFFFFFFFFFFFFFF1,
                    64'h0, 64'hFFFFFFFFFFFFFFF1, 32'hFFFFFFF1};
        vecs[2] = '{33'h1_FFFFFFFD, 33'h0_00000005, 1'b1, 64'hFFFFFFFFFFFFFFF1,
                    64'h0, 64'hFFFFFFFFFFFFFFF1, 32'hFFFFFFFF};
        vecs[3] = '{33'h1_00000000, 33'h1_FFFFFFFF, 1'b0, 64'hFFFF000100000000,
                    64'h0001000000000000, 64'h0000000100000000, 32'h00000000};
        vecs[4] = '{33'h0_00012345, 33'h0_00010002, 1'b1, 64'h000000000002468A,
                    64'h0000000123450000, 64'h000000012347468A, 32'h00000001};

        repeat (3) @(negedge clk);
        chk("reset_empty", 128'(X1X2_EMPTY_SX1), 128'(1));
        chk("reset_res", RES_RX1, 128'(0));
        chk("reset_pop", 128'(X0X1_POP_SX1), 128'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Table vectors: push one, inspect the head, pop it.
        for (int i = 0; i < 5; i++) begin
            cycle(vecs[i].op1, vecs[i].op2, vecs[i].msb, 1'b1, 1'b0, 1'b0, 1'b0);
            X0X1_EMPTY_SX0 = 1'b1;
            #1;
            chk("vec_not_empty", 128'(X1X2_EMPTY_SX1), 128'(0));
            chk("vec_lo", 128'(RES_RX1[63:0]), 128'(vecs[i].exp_lo));
            chk("vec_hi", 128'(RES_RX1[127:64]), 128'(vecs[i].exp_hi));
            sum = RES_RX1[63:0] + RES_RX1[127:64];
            chk("vec_sum", 128'(sum), 128'(vecs[i].exp_sum));
            chk("vec_x2_word", 128'(x2_word(sum, SELECT_MSB_RX1)), 128'(vecs[i].exp_word));
            cycle('0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        idle();

        // Backpressure: four offers with no X2 pop, only DEPTH accepted.
        for (int i = 0; i < 4; i++) begin
            cycle(33'(i + 1), 33'(i + 10), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        // Pop-through while full, then confirm still full.
        cycle(33'd99, 33'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        X0X1_EMPTY_SX0 = 1'b0;
        X1X2_POP_SX2   = 1'b0;
        #1;
        chk("still_full", 128'(X0X1_POP_SX1), 128'(0));
        cycle(33'd5, 33'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush with X0X1 non-empty: no pop strobe, FIFO empties.
        FLUSH_SX1 = 1'b1;
        #1;
        chk("flush_no_pop", 128'(X0X1_POP_SX1), 128'(0));
        cycle(33'd8, 33'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("flush_empty", 128'(X1X2_EMPTY_SX1), 128'(1));
        cycle(33'd11, 33'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();

        // Asynchronous reset with one entry queued.
        cycle(33'd123, 33'd456, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        X0X1_EMPTY_SX0 = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_empty", 128'(X1X2_EMPTY_SX1), 128'(1));
        chk("async_res", RES_RX1, 128'(0));
        chk("async_pop", 128'(X0X1_POP_SX1), 128'(0));
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(33'd7, 33'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        sum = RES_RX1[63:0] + RES_RX1[127:64];
        chk("after_reset_sum", 128'(sum), 128'(42));
        cycle('0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Pop while empty is ignored, then a streaming run across pointer wrap.
        cycle('0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle('0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(33'(1000 + i), 33'(3 * i + 1), i[0], 1'b0, 1'b0, 1'b1, 1'b0);
        end
        cycle('0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            save_pop = ($urandom_range(0, 1) == 1);
            cycle({$urandom_range(0, 1) == 1, $urandom()},
                  {$urandom_range(0, 1) == 1, $urandom()},
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, save_pop,
                  $urandom_range(0, 15) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
